// File: rtl/bp_pkg.sv
// Shared definitions for the branch recovery table: entry layout, PC step and default sizes.
package bp_pkg;

    localparam int DEF_ENTRIES = 8;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_CNT_W   = 2;
    localparam int DEF_STAT_W  = 16;
    localparam int PC_STEP     = 4;

    // Canonical entry layout at the default sizes; the table keeps the same
    // fields in per-field arrays so that XLEN and CNT_W stay parametrisable.
    typedef struct packed {
        logic                 valid;
        logic [DEF_XLEN-1:0]  pc;
        logic [DEF_XLEN-1:0]  target;
        logic                 taken;
        logic [DEF_CNT_W-1:0] conf;
    } brt_entry_t;

endpackage

// File: rtl/brt_match_enc.sv
// Fully associative PC comparator with a lowest-index priority encoder.
module brt_match_enc
    import bp_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int XLEN    = DEF_XLEN,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]           valid,
    input  logic [ENTRIES-1:0][XLEN-1:0] pcs,
    input  logic [XLEN-1:0]              key,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (pcs[i] == key)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_recovery_table.sv
// Fully associative table of in-flight branch predictions: allocated by IF,
// checked by EX, producing a mispredict flag and the corrected fetch PC.
module branch_recovery_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int XLEN    = DEF_XLEN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int STAT_W  = DEF_STAT_W,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int OCC_W   = $clog2(ENTRIES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic [XLEN-1:0]   alloc_target,
    input  logic              alloc_taken,
    input  logic              res_en,
    input  logic [XLEN-1:0]   res_pc,
    input  logic              res_taken,
    input  logic              flush,
    output logic              res_hit,
    output logic              mispredict,
    output logic [XLEN-1:0]   recover_pc,
    output logic [CNT_W-1:0]  res_conf,
    output logic [OCC_W-1:0]  occupancy,
    output logic [STAT_W-1:0] mispred_cnt
);

    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][XLEN-1:0]  pc_q;
    logic [ENTRIES-1:0][XLEN-1:0]  target_q;
    logic [ENTRIES-1:0]            taken_q;
    logic [ENTRIES-1:0][CNT_W-1:0] conf_q;
    logic [IDX_W-1:0]              victim_q;
    logic [STAT_W-1:0]             mispred_cnt_q;

    logic             res_match;
    logic [IDX_W-1:0] res_idx;
    logic             alloc_match;
    logic [IDX_W-1:0] alloc_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] alloc_slot;

    brt_match_enc #(
        .ENTRIES (ENTRIES),
        .XLEN    (XLEN),
        .IDX_W   (IDX_W)
    ) u_res_match (
        .valid (valid_q),
        .pcs   (pc_q),
        .key   (res_pc),
        .hit   (res_match),
        .idx   (res_idx)
    );

    brt_match_enc #(
        .ENTRIES (ENTRIES),
        .XLEN    (XLEN),
        .IDX_W   (IDX_W)
    ) u_alloc_match (
        .valid (valid_q),
        .pcs   (pc_q),
        .key   (alloc_pc),
        .hit   (alloc_match),
        .idx   (alloc_idx)
    );

    // Resolve-side outputs: lookup is combinational so EX can redirect fetch in the same cycle.
    always_comb begin
        res_hit    = res_match;
        mispredict = res_en && res_match && (taken_q[res_idx] != res_taken);
        recover_pc = '0;
        res_conf   = '0;
        if (res_match) begin
            recover_pc = res_taken ? target_q[res_idx] : (res_pc + XLEN'(PC_STEP));
            res_conf   = conf_q[res_idx];
        end
    end

    // Pick where a new prediction lands: existing entry, lowest free slot, else the victim.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        if (alloc_match) begin
            alloc_slot = alloc_idx;
        end else if (free_found) begin
            alloc_slot = free_idx;
        end else begin
            alloc_slot = victim_q;
        end
    end

    // Occupancy is a popcount of the valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign mispred_cnt = mispred_cnt_q;

    // Table state update: reset, then flush, then resolve followed by alloc so alloc wins on a shared entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q       <= '0;
            pc_q          <= '0;
            target_q      <= '0;
            taken_q       <= '0;
            conf_q        <= '0;
            victim_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (mispredict && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
            end
            if (flush) begin
                valid_q  <= '0;
                victim_q <= '0;
            end else begin
                if (res_en && res_match) begin
                    if (mispredict) begin
                        taken_q[res_idx] <= res_taken;
                        conf_q[res_idx]  <= '0;
                    end else if (conf_q[res_idx] != '1) begin
                        conf_q[res_idx] <= conf_q[res_idx] + CNT_W'(1);
                    end
                end
                if (alloc_en) begin
                    valid_q[alloc_slot]  <= 1'b1;
                    pc_q[alloc_slot]     <= alloc_pc;
                    target_q[alloc_slot] <= alloc_target;
                    taken_q[alloc_slot]  <= alloc_taken;
                    if (alloc_match && (taken_q[alloc_idx] == alloc_taken)) begin
                        conf_q[alloc_slot] <= conf_q[alloc_idx];
                    end else begin
                        conf_q[alloc_slot] <= '0;
                    end
                    if (!alloc_match && !free_found) begin
                        victim_q <= victim_q + IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_recovery_table.sv
// Directed self-checking bench for branch_recovery_table at default parameters.
module tb_branch_recovery_table;

    logic        clk;
    logic        reset;
    logic        alloc_en;
    logic [31:0] alloc_pc;
    logic [31:0] alloc_target;
    logic        alloc_taken;
    logic        res_en;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        flush;
    logic        res_hit;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [1:0]  res_conf;
    logic [3:0]  occupancy;
    logic [15:0] mispred_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;
    logic cur_taken;

    branch_recovery_table dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_pc     (alloc_pc),
        .alloc_target (alloc_target),
        .alloc_taken  (alloc_taken),
        .res_en       (res_en),
        .res_pc       (res_pc),
        .res_taken    (res_taken),
        .flush        (flush),
        .res_hit      (res_hit),
        .mispredict   (mispredict),
        .recover_pc   (recover_pc),
        .res_conf     (res_conf),
        .occupancy    (occupancy),
        .mispred_cnt  (mispred_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic a_en, input logic [31:0] a_pc, input logic [31:0] a_tgt,
                                 input logic a_tk, input logic r_en, input logic [31:0] r_pc,
                                 input logic r_tk, input logic fl);
        alloc_en     = a_en;
        alloc_pc     = a_pc;
        alloc_target = a_tgt;
        alloc_taken  = a_tk;
        res_en       = r_en;
        res_pc       = r_pc;
        res_taken    = r_tk;
        flush        = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doAlloc(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        applyStimulus(1'b1, pc, tgt, tk, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic doResolve(input logic [31:0] pc, input logic tk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, pc, tk, 1'b0);
        tick();
    endtask

    task automatic peek(input logic [31:0] pc, input logic tk);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, pc, tk, 1'b0);
    endtask

    task automatic doFlush();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_occ", occupancy, 0);
        checkOutput("rst_cnt", mispred_cnt, 0);
        checkOutput("rst_hit", res_hit, 0);
        checkOutput("rst_misp", mispredict, 0);
        checkOutput("rst_rpc", recover_pc, 0);
        checkOutput("rst_conf", res_conf, 0);
        reset = 1'b1;

        // Taken prediction resolved not-taken.
        doAlloc(32'h100, 32'h200, 1'b1);
        peek(32'h100, 1'b0);
        checkOutput("m1_hit", res_hit, 1);
        checkOutput("m1_misp", mispredict, 1);
        checkOutput("m1_rpc", recover_pc, 32'h104);
        tick();
        exp_cnt++;
        peek(32'h100, 1'b0);
        checkOutput("m1_newtaken", mispredict, 0);
        checkOutput("m1_cnt", mispred_cnt, exp_cnt);
        checkOutput("m1_occ", occupancy, 1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0);
        checkOutput("resen0_hit", res_hit, 1);
        checkOutput("resen0_misp", mispredict, 0);

        // Not-taken prediction resolved taken, then confidence saturation.
        doAlloc(32'h40, 32'h80, 1'b0);
        peek(32'h40, 1'b1);
        checkOutput("m2_misp", mispredict, 1);
        checkOutput("m2_rpc", recover_pc, 32'h80);
        tick();
        exp_cnt++;
        for (int i = 0; i < 4; i++) begin
            peek(32'h40, 1'b1);
            checkOutput($sformatf("conf_step%0d", i), res_conf, (i > 3) ? 3 : i);
            tick();
        end
        peek(32'h40, 1'b1);
        checkOutput("conf_sat", res_conf, 3);
        checkOutput("conf_nomisp", mispredict, 0);
        checkOutput("m2_cnt", mispred_cnt, exp_cnt);

        // Flush with a simultaneous alloc discards the alloc.
        applyStimulus(1'b1, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        peek(32'h500, 1'b1);
        checkOutput("flush_occ", occupancy, 0);
        checkOutput("flush_hit", res_hit, 0);
        checkOutput("flush_conf", res_conf, 0);

        // Fill the table, then replace via the victim pointer.
        for (int i = 0; i < 8; i++) begin
            doAlloc(32'(i * 4), 32'h1000, 1'b0);
        end
        checkOutput("fill_occ", occupancy, 8);
        doAlloc(32'h300, 32'h3000, 1'b1);
        doAlloc(32'h304, 32'h3004, 1'b1);
        peek(32'h0, 1'b0);
        checkOutput("vic_miss0", res_hit, 0);
        peek(32'h4, 1'b0);
        checkOutput("vic_miss4", res_hit, 0);
        peek(32'h8, 1'b0);
        checkOutput("vic_keep8", res_hit, 1);
        peek(32'h304, 1'b1);
        checkOutput("vic_hit304", res_hit, 1);
        checkOutput("vic_rpc304", recover_pc, 32'h3004);
        checkOutput("vic_occ", occupancy, 8);

        // Same-cycle alloc and resolve on one entry: alloc fields win, count still moves.
        doFlush();
        doAlloc(32'h100, 32'h200, 1'b1);
        doResolve(32'h100, 1'b1);
        doResolve(32'h100, 1'b1);
        applyStimulus(1'b1, 32'h100, 32'h900, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        checkOutput("same_misp", mispredict, 1);
        tick();
        exp_cnt++;
        peek(32'h100, 1'b1);
        checkOutput("same_rpc", recover_pc, 32'h900);
        checkOutput("same_misp2", mispredict, 1);
        checkOutput("same_conf", res_conf, 0);
        checkOutput("same_cnt", mispred_cnt, exp_cnt);
        doResolve(32'h100, 1'b0);
        doResolve(32'h100, 1'b0);
        doAlloc(32'h100, 32'hA00, 1'b0);
        peek(32'h100, 1'b1);
        checkOutput("keep_conf", res_conf, 2);
        checkOutput("keep_rpc", recover_pc, 32'hA00);

        // Recovery PC wraps at the top of the address space.
        doAlloc(32'hFFFF_FFFC, 32'h10, 1'b1);
        peek(32'hFFFF_FFFC, 1'b0);
        checkOutput("wrap_misp", mispredict, 1);
        checkOutput("wrap_rpc", recover_pc, 32'h0);
        tick();
        exp_cnt++;
        cur_taken = 1'b0;

        // Drive the statistics counter to all-ones and past it.
        while (exp_cnt < 16'hFFFF) begin
            cur_taken = ~cur_taken;
            doResolve(32'hFFFF_FFFC, cur_taken);
            exp_cnt++;
        end
        checkOutput("stat_full", mispred_cnt, 16'hFFFF);
        peek(32'hFFFF_FFFC, ~cur_taken);
        checkOutput("stat_last_misp", mispredict, 1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("stat_sat", mispred_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
